// File: rtl/rotary_param_ctrl.sv
// Rotary encoder / push-button front end editing a small bank of parameters.
// NAV steps the slot index, EDIT steps the selected value, long press zeroes the selected slot.
module rotary_param_ctrl #(
   parameter int p_SEL_WIDTH         = 2,
   parameter int p_WIDTH             = 4,
   parameter int p_WRAP              = 0,
   parameter int p_LONG_CNT_WIDTH    = 20,
   parameter int p_TIMEOUT_CNT_WIDTH = 24
) (
   input  logic                                  CLK,
   input  logic                                  RST_N,
   input  logic                                  i_step,
   input  logic                                  i_step_cw,
   input  logic                                  i_btn,
   output logic [p_SEL_WIDTH-1:0]                ov_sel,
   output logic                                  o_edit,
   output logic [p_WIDTH-1:0]                    ov_value,
   output logic [(2**p_SEL_WIDTH)*p_WIDTH-1:0]   ov_params,
   output logic                                  o_update
);

   localparam int N_SLOTS = 2**p_SEL_WIDTH;

   localparam logic [p_SEL_WIDTH-1:0]         SEL_ONE  = 1;
   localparam logic [p_WIDTH-1:0]             VAL_ONE  = 1;
   localparam logic [p_WIDTH-1:0]             VAL_MAX  = '1;
   localparam logic [p_WIDTH-1:0]             VAL_ZERO = '0;
   localparam logic [p_LONG_CNT_WIDTH-1:0]    LONG_ONE = 1;
   localparam logic [p_LONG_CNT_WIDTH-1:0]    LONG_MAX = '1;
   localparam logic [p_TIMEOUT_CNT_WIDTH-1:0] IDLE_ONE = 1;
   localparam logic [p_TIMEOUT_CNT_WIDTH-1:0] IDLE_MAX = '1;

   typedef enum logic {
      S_NAV  = 1'b0,
      S_EDIT = 1'b1
   } state_t;

   state_t                         state_q, state_d;
   logic [p_SEL_WIDTH-1:0]         sel_q, sel_d;
   logic [p_WIDTH-1:0]             slot_q [N_SLOTS];
   logic [p_WIDTH-1:0]             slot_d [N_SLOTS];
   logic                           btn_hist_q, btn_hist_d;
   logic [p_LONG_CNT_WIDTH-1:0]    press_cnt_q, press_cnt_d;
   logic [p_TIMEOUT_CNT_WIDTH-1:0] idle_q, idle_d;
   logic                           update_q, update_d;

   logic                           btn_rise, btn_fall, btn_held;
   logic                           long_ev, short_ev;
   logic [p_WIDTH-1:0]             cur_val, new_val;

   // One encoder detent applied to a value, saturating or modulo depending on p_WRAP.
   function automatic logic [p_WIDTH-1:0] step_value(input logic [p_WIDTH-1:0] v,
                                                     input logic               up);
      logic [p_WIDTH-1:0] r;
      if (up) begin
         r = ((p_WRAP == 0) && (v == VAL_MAX)) ? v : v + VAL_ONE;
      end else begin
         r = ((p_WRAP == 0) && (v == VAL_ZERO)) ? v : v - VAL_ONE;
      end
      return r;
   endfunction

   always_comb begin
      btn_rise    = i_btn & ~btn_hist_q;
      btn_fall    = ~i_btn & btn_hist_q;
      btn_held    = i_btn & btn_hist_q;
      btn_hist_d  = i_btn;

      press_cnt_d = press_cnt_q;
      if (btn_rise) begin
         press_cnt_d = '0;
      end else if (btn_held && (press_cnt_q != LONG_MAX)) begin
         press_cnt_d = press_cnt_q + LONG_ONE;
      end

      // Long press fires only on the cycle the counter first saturates.
      long_ev  = btn_held && (press_cnt_q != LONG_MAX) && (press_cnt_d == LONG_MAX);
      short_ev = btn_fall && (press_cnt_q != LONG_MAX);

      state_d = state_q;
      sel_d   = sel_q;
      idle_d  = idle_q;
      slot_d  = slot_q;
      cur_val = slot_q[sel_q];
      new_val = cur_val;

      case (state_q)
         S_NAV: begin
            idle_d = '0;
            if (i_step) begin
               sel_d = i_step_cw ? sel_q + SEL_ONE : sel_q - SEL_ONE;
            end
            if (short_ev) begin
               state_d = S_EDIT;
            end
         end
         S_EDIT: begin
            if (i_step) begin
               new_val = step_value(cur_val, i_step_cw);
            end
            if (i_step || i_btn) begin
               idle_d = '0;
            end else if (idle_q == IDLE_MAX) begin
               idle_d  = '0;
               state_d = S_NAV;
            end else begin
               idle_d = idle_q + IDLE_ONE;
            end
            if (short_ev) begin
               state_d = S_NAV;
            end
         end
         default: begin
            state_d = S_NAV;
            idle_d  = '0;
         end
      endcase

      // Long press overrides any concurrent edit of the selected slot.
      if (long_ev) begin
         new_val = VAL_ZERO;
      end

      slot_d[sel_q] = new_val;
      update_d      = (new_val != cur_val);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_NAV;
         sel_q       <= '0;
         btn_hist_q  <= 1'b0;
         press_cnt_q <= '0;
         idle_q      <= '0;
         update_q    <= 1'b0;
         for (int k = 0; k < N_SLOTS; k++) begin
            slot_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         btn_hist_q  <= btn_hist_d;
         press_cnt_q <= press_cnt_d;
         idle_q      <= idle_d;
         update_q    <= update_d;
         for (int k = 0; k < N_SLOTS; k++) begin
            slot_q[k] <= slot_d[k];
         end
      end
   end

   always_comb begin
      ov_params = '0;
      for (int k = 0; k < N_SLOTS; k++) begin
         ov_params[k*p_WIDTH +: p_WIDTH] = slot_q[k];
      end
   end

   assign ov_sel   = sel_q;
   assign o_edit   = (state_q == S_EDIT);
   assign ov_value = slot_q[sel_q];
   assign o_update = update_q;

endmodule

// File: tb/tb_rotary_param_ctrl.sv
// Directed bench: a saturating and a wrapping instance share the same stimulus.
module tb_rotary_param_ctrl;

   localparam int SW = 2;
   localparam int VW = 4;
   localparam int PW = (2**SW)*VW;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          i_step = 1'b0;
   logic          i_step_cw = 1'b0;
   logic          i_btn = 1'b0;

   logic [SW-1:0] sel_s, sel_w;
   logic          edit_s, edit_w;
   logic [VW-1:0] val_s, val_w;
   logic [PW-1:0] par_s, par_w;
   logic          upd_s, upd_w;

   int n_chk = 0;
   int n_err = 0;
   int upd_cnt_s = 0;
   int upd_cnt_w = 0;

   rotary_param_ctrl #(
      .p_SEL_WIDTH(SW), .p_WIDTH(VW), .p_WRAP(0),
      .p_LONG_CNT_WIDTH(4), .p_TIMEOUT_CNT_WIDTH(5)
   ) u_sat (
      .CLK(CLK), .RST_N(RST_N), .i_step(i_step), .i_step_cw(i_step_cw), .i_btn(i_btn),
      .ov_sel(sel_s), .o_edit(edit_s), .ov_value(val_s), .ov_params(par_s), .o_update(upd_s)
   );

   rotary_param_ctrl #(
      .p_SEL_WIDTH(SW), .p_WIDTH(VW), .p_WRAP(1),
      .p_LONG_CNT_WIDTH(4), .p_TIMEOUT_CNT_WIDTH(5)
   ) u_wrap (
      .CLK(CLK), .RST_N(RST_N), .i_step(i_step), .i_step_cw(i_step_cw), .i_btn(i_btn),
      .ov_sel(sel_w), .o_edit(edit_w), .ov_value(val_w), .ov_params(par_w), .o_update(upd_w)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and sample 1 time unit later; tally update pulses.
   task automatic tick();
      @(posedge CLK);
      #1;
      if (upd_s) upd_cnt_s++;
      if (upd_w) upd_cnt_w++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic step(input logic cw);
      i_step    = 1'b1;
      i_step_cw = cw;
      tick();
      i_step    = 1'b0;
      i_step_cw = 1'b0;
   endtask

   task automatic press(input int held);
      i_btn = 1'b1;
      ticks(held);
      i_btn = 1'b0;
      tick();
   endtask

   initial begin
      #1;
      chk("rst_sel", 32'(sel_s), 0);
      chk("rst_edit", 32'(edit_s), 0);
      chk("rst_params", par_s, 0);
      chk("rst_update", 32'(upd_s), 0);
      #3 RST_N = 1'b1;
      ticks(2);

      // NAV rotation, wrapping through the slot range
      for (int i = 0; i < 5; i++) step(1'b1);
      chk("nav_cw5_sel", 32'(sel_s), 1);
      step(1'b0);
      step(1'b0);
      chk("nav_ccw2_sel", 32'(sel_s), 3);
      chk("nav_upd_cnt", 32'(upd_cnt_s), 0);
      chk("nav_params", par_s, 0);
      chk("nav_edit", 32'(edit_s), 0);

      press(3);
      chk("short_enter_edit", 32'(edit_s), 1);
      chk("short_sel_kept", 32'(sel_s), 3);

      upd_cnt_s = 0;
      upd_cnt_w = 0;
      for (int i = 0; i < 17; i++) step(1'b1);
      chk("wrap17_value", 32'(val_w), 1);
      chk("wrap17_upd_cnt", 32'(upd_cnt_w), 17);
      step(1'b1);
      chk("sat18_value", 32'(val_s), 15);
      chk("sat18_upd_cnt", 32'(upd_cnt_s), 15);
      chk("sat18_params", par_s, 32'h0000_F000);
      chk("wrap18_value", 32'(val_w), 2);
      step(1'b0);
      chk("sat_ccw_value", 32'(val_s), 14);
      chk("wrap_ccw_value", 32'(val_w), 1);

      // Idle timeout from the last step
      ticks(31);
      chk("idle31_edit", 32'(edit_s), 1);
      tick();
      chk("idle32_edit", 32'(edit_s), 0);
      chk("idle_val_kept_s", 32'(val_s), 14);
      chk("idle_val_kept_w", 32'(val_w), 1);

      // Step during idle count restarts the timeout
      press(3);
      chk("reenter_edit", 32'(edit_s), 1);
      ticks(29);
      step(1'b1);
      chk("restart_step_val", 32'(val_s), 15);
      ticks(31);
      chk("restart31_edit", 32'(edit_w), 1);
      tick();
      chk("restart32_edit", 32'(edit_w), 0);

      // Long press clears the selected slot once
      press(3);
      step(1'b0);
      chk("pre_long_val", 32'(val_s), 14);
      upd_cnt_s = 0;
      upd_cnt_w = 0;
      i_btn = 1'b1;
      ticks(15);
      chk("long15_val", 32'(val_s), 14);
      tick();
      chk("long16_val", 32'(val_s), 0);
      chk("long16_upd", 32'(upd_s), 1);
      ticks(4);
      i_btn = 1'b0;
      tick();
      chk("long_upd_cnt_s", 32'(upd_cnt_s), 1);
      chk("long_upd_cnt_w", 32'(upd_cnt_w), 1);
      chk("long_release_edit", 32'(edit_s), 1);
      upd_cnt_s = 0;
      press(20);
      chk("long_again_upd_cnt", 32'(upd_cnt_s), 0);
      chk("long_again_edit", 32'(edit_s), 1);

      // Load slot 2 = 9, then reset asynchronously mid-press
      press(3);
      chk("exit_edit", 32'(edit_s), 0);
      step(1'b0);
      press(3);
      for (int i = 0; i < 9; i++) step(1'b1);
      chk("slot2_params_s", par_s, 32'h0000_0900);
      chk("slot2_params_w", par_w, 32'h0000_0900);
      i_btn = 1'b1;
      ticks(2);
      #3 RST_N = 1'b0;
      #1;
      chk("arst_sel", 32'(sel_s), 0);
      chk("arst_edit", 32'(edit_s), 0);
      chk("arst_params", par_s, 0);
      chk("arst_value", 32'(val_w), 0);
      chk("arst_update", 32'(upd_s), 0);
      #2 RST_N = 1'b1;
      ticks(5);
      chk("held_rst_edit", 32'(edit_s), 0);
      i_btn = 1'b0;
      tick();
      chk("post_rst_short_edit", 32'(edit_s), 1);
      chk("post_rst_sel", 32'(sel_s), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rotary_param_ctrl.md
Name: rotary_param_ctrl

Overview:
- Sequences a rotary encoder and push-button into a small bank of user-editable parameters, e.g. LED brightness or colour, or counter step.
- Sits between the encoder decoder (step pulse plus direction) and the debounced button on the input side, and the consumers of the parameter bank on the output side.
- Two-mode UI: NAV rotates through parameter slots; EDIT rotates the selected slot's value. Long press restores the selected slot to zero.

Parameters:
p_SEL_WIDTH, 2, slot index width; number of slots = 2**p_SEL_WIDTH
p_WIDTH, 4, width of each parameter value
p_WRAP, 0, EDIT arithmetic: 0 = saturate at 0 / max, 1 = modulo 2**p_WIDTH
p_LONG_CNT_WIDTH, 20, press counter width; long-press threshold = 2**p_LONG_CNT_WIDTH-1 cycles held
p_TIMEOUT_CNT_WIDTH, 24, idle counter width; EDIT timeout = 2**p_TIMEOUT_CNT_WIDTH-1 idle cycles

Ports:
CLK  in  1  system clock
RST_N  in  1  reset, asynchronous assert, active-low
i_step  in  1  one-cycle pulse per encoder detent
i_step_cw  in  1  direction qualifier for i_step: 1 = clockwise (+1), 0 = counter-clockwise (-1)
i_btn  in  1  synchronised, debounced button level; 1 = pressed
ov_sel  out  p_SEL_WIDTH  selected slot index
o_edit  out  1  1 = EDIT state, 0 = NAV state
ov_value  out  p_WIDTH  value of the selected slot (combinational mux of registers)
ov_params  out  (2**p_SEL_WIDTH)*p_WIDTH  flattened bank; slot k at bits [k*p_WIDTH +: p_WIDTH]
o_update  out  1  one-cycle pulse, asserted the cycle after any slot value changes

Behaviour:
- Reset (RST_N low):
  - Takes effect immediately, including mid-press or mid-edit.
  - State = NAV; ov_sel = 0; all slots = 0; o_update = 0.
  - Press counter, idle counter and button-history register = 0.
  - If the button is held as reset releases, the first clock sees a rising edge and a new press starts.
- Button classification:
  - Rising edge of i_btn (history 0, current 1) clears the press counter and arms a press.
  - While held, the counter increments and saturates at all-ones.
  - The cycle the counter becomes all-ones is a long-press event; it fires once per press.
  - Falling edge with counter not all-ones is a short-press event, acted on at release.
  - Falling edge after a long press produces no event.
- NAV state:
  - i_step cw: ov_sel + 1, wraps max->0. i_step ccw: ov_sel - 1, wraps 0->max.
  - Short press: enter EDIT; ov_sel is unchanged.
- EDIT state:
  - i_step cw: selected slot + 1. i_step ccw: selected slot - 1.
  - p_WRAP=0: value held at max on +1 and at 0 on -1; no o_update when the value does not change.
  - p_WRAP=1: value wraps modulo 2**p_WIDTH.
  - Short press: return to NAV.
  - Idle counter: cleared on entry to EDIT, on any i_step, and while i_btn = 1. Otherwise it increments.
  - When the idle counter reaches all-ones: return to NAV and clear the counter. The selected value is retained.
  - The idle counter is held at 0 in NAV.
- Long press, either state:
  - Selected slot <= 0 and o_update pulses, unless the slot was already 0.
  - State is unchanged.
- Simultaneous events: each cycle decodes the step using the state at the start of the cycle. Consequences:
  - Step and short press in the same cycle in NAV: ov_sel moves, and EDIT starts on the new slot.
  - Step and short press in the same cycle in EDIT: value is updated, then the block returns to NAV.
  - Step and long press in the same cycle in EDIT: long press wins; slot = 0.
  - Step and timeout in the same cycle: the step clears the idle counter, so no timeout occurs.
- i_step_cw is ignored when i_step = 0. ov_params, ov_sel and o_edit are registered; ov_value is a mux of registers. Latency from event to output is 1 cycle.

Test Plan:
- Bench parameters: p_SEL_WIDTH=2, p_WIDTH=4, p_LONG_CNT_WIDTH=4 (long = 15 held cycles), p_TIMEOUT_CNT_WIDTH=5 (31 idle cycles).
- Reset then 5 cw steps in NAV -> ov_sel = 1 (wraps through 3->0); 2 ccw -> ov_sel = 3; o_update never pulses, ov_params = 0.
- Short press (held 3 cycles) -> o_edit = 1 after release. 18 cw steps with p_WRAP=0 -> slot 3 = 15, o_update pulses exactly 15 times. 1 ccw -> 14.
- Same sequence with p_WRAP=1: 17 cw steps from 0 -> slot 3 = 1, o_update pulses 17 times.
- EDIT, then no activity for 31 cycles -> o_edit = 0 on cycle 32, value retained. Step at cycle 30 -> timeout restarts from 0.
- Slot 3 = 14, press held 20 cycles -> slot 3 = 0 with a single o_update on cycle 16; release gives no mode change. Repeat long press -> no o_update.
- Pull RST_N low mid-press while in EDIT with slot 2 = 9 -> all outputs 0 asynchronously. Release with i_btn still high, then release the button after 5 cycles -> short press -> o_edit = 1.
